// File: rtl/pagerank_pkg.sv
// Shared types and defaults for the PageRank per-vertex reduction sequencer.
// The DAMP state is only reachable when PAGERANK_DAMPING_EN is defined.
package pagerank_pkg;

  localparam int W_DEF  = 32;
  localparam int CW_DEF = 16;
  localparam int VW_DEF = 16;

  // Damping in Q8: 217/256 ~= 0.85, 38/256 ~= 0.15
  localparam int DAMP_NUM_Q8   = 217;
  localparam int DAMP_SHIFT_Q8 = 8;
  localparam int BASE_RANK_Q8  = 38;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    DAMP  = 3'd4,
    DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/pagerank_damp.sv
// Combinational damping stage: ((acc * DAMP_NUM) >> DAMP_SHIFT) + BASE_RANK.
// Instantiated by pagerank_reduce_ctrl only when PAGERANK_DAMPING_EN is defined.
module pagerank_damp
  import pagerank_pkg::*;
#(
  parameter int W          = W_DEF,
  parameter int DAMP_NUM   = DAMP_NUM_Q8,
  parameter int DAMP_SHIFT = DAMP_SHIFT_Q8,
  parameter int BASE_RANK  = BASE_RANK_Q8
) (
  input  logic [W-1:0] acc,
  output logic [W-1:0] damped
);

  // Full 2W product so the shift sees every bit before truncation back to W
  function automatic logic [W-1:0] damp_q(input logic [W-1:0] a);
    logic [2*W-1:0] prod;
    prod = {{W{1'b0}}, a} * (2*W)'(DAMP_NUM);
    prod = prod >> DAMP_SHIFT;
    return prod[W-1:0] + W'(BASE_RANK);
  endfunction

  assign damped = damp_q(acc);

endmodule

// File: rtl/pagerank_reduce_ctrl.sv
// Sequences one reduction per incoming edge of a vertex and emits its accumulated rank.
// Optional feature: define PAGERANK_DAMPING_EN to add the one-cycle DAMP state.
module pagerank_reduce_ctrl
  import pagerank_pkg::*;
#(
  parameter int W          = W_DEF,
  parameter int CW         = CW_DEF,
  parameter int VW         = VW_DEF,
  parameter int DAMP_NUM   = DAMP_NUM_Q8,
  parameter int DAMP_SHIFT = DAMP_SHIFT_Q8,
  parameter int BASE_RANK  = BASE_RANK_Q8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [VW-1:0] vertex_id,
  input  logic [CW-1:0] num_edges,
  output logic          busy,
  input  logic          edge_valid,
  output logic          edge_ready,
  input  logic [W-1:0]  edge_page_rank,
  input  logic [W-1:0]  edge_out_deg,
  output logic          red_start,
  output logic [W-1:0]  red_sum,
  output logic [W-1:0]  red_page_rank,
  output logic [W-1:0]  red_out_deg,
  input  logic [W-1:0]  red_new_sum,
  input  logic          red_done,
  output logic          result_valid,
  output logic [VW-1:0] result_vertex,
  output logic [W-1:0]  result_sum,
  output logic          result_zero_deg
);

  if (DAMP_SHIFT < 0 || DAMP_SHIFT >= 2*W || DAMP_NUM < 0 || BASE_RANK < 0) begin : g_param_check
    $error("pagerank_reduce_ctrl: invalid damping parameters");
  end

`ifdef PAGERANK_DAMPING_EN
  localparam state_t LAST_ST = DAMP;
  logic [W-1:0] damped;

  pagerank_damp #(
    .W(W), .DAMP_NUM(DAMP_NUM), .DAMP_SHIFT(DAMP_SHIFT), .BASE_RANK(BASE_RANK)
  ) u_damp (
    .acc   (red_sum),
    .damped(damped)
  );
`else
  localparam state_t LAST_ST = DONE;
`endif

  state_t        state, state_next;
  logic [VW-1:0] vid;
  logic [CW-1:0] nedges, cnt, cnt_inc;
  logic          zdeg;
  logic [VW-1:0] fin_vertex;
  logic [W-1:0]  fin_sum;
  logic          fin_zdeg;

  // The accumulator doubles as the running-sum operand; it only moves on WAIT exit
  assign cnt_inc = cnt + CW'(1);

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next   = state;
    busy         = (state != IDLE);
    edge_ready   = 1'b0;
    red_start    = 1'b0;
    result_valid = 1'b0;
    case (state)
      IDLE:  if (start) state_next = (num_edges == '0) ? DONE : FETCH;
      FETCH: begin
        edge_ready = 1'b1;
        if (edge_valid) begin
          if (edge_out_deg == '0) state_next = (cnt_inc < nedges) ? FETCH : LAST_ST;
          else                    state_next = ISSUE;
        end
      end
      ISSUE: begin
        red_start  = 1'b1;
        state_next = WAIT;
      end
      WAIT:  if (red_done) state_next = (cnt < nedges) ? FETCH : LAST_ST;
`ifdef PAGERANK_DAMPING_EN
      DAMP:  state_next = DONE;
`endif
      DONE: begin
        result_valid = 1'b1;
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Values the result registers take on the transition into DONE
  always_comb begin
    fin_vertex = vid;
    fin_zdeg   = zdeg;
    fin_sum    = red_sum;
    case (state)
      IDLE: begin
        fin_vertex = vertex_id;
        fin_zdeg   = 1'b0;
        fin_sum    = '0;
      end
      FETCH: fin_zdeg = zdeg | (edge_out_deg == '0);
      WAIT:  fin_sum  = red_new_sum;
`ifdef PAGERANK_DAMPING_EN
      DAMP:  fin_sum  = damped;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      vid             <= '0;
      nedges          <= '0;
      cnt             <= '0;
      zdeg            <= 1'b0;
      red_sum         <= '0;
      red_page_rank   <= '0;
      red_out_deg     <= '0;
      result_vertex   <= '0;
      result_sum      <= '0;
      result_zero_deg <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          vid     <= vertex_id;
          nedges  <= num_edges;
          cnt     <= '0;
          zdeg    <= 1'b0;
          red_sum <= '0;
        end
        FETCH: if (edge_valid) begin
          red_page_rank <= edge_page_rank;
          red_out_deg   <= edge_out_deg;
          cnt           <= cnt_inc;
          if (edge_out_deg == '0) zdeg <= 1'b1;
        end
        WAIT: if (red_done) red_sum <= red_new_sum;
        default: ;
      endcase
      if (state_next == DONE) begin
        result_vertex   <= fin_vertex;
        result_sum      <= fin_sum;
        result_zero_deg <= fin_zdeg;
      end
    end
  end

endmodule

// File: tb/tb_pagerank_reduce_ctrl.sv
// Randomized bench for pagerank_reduce_ctrl: a reduction-unit responder plus a
// fold-over-edges reference model; define PAGERANK_DAMPING_EN to check the damped build.
module tb_pagerank_reduce_ctrl;

  localparam int W  = 32;
  localparam int CW = 16;
  localparam int VW = 16;
`ifdef PAGERANK_DAMPING_EN
  localparam int DL = 1;
`else
  localparam int DL = 0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [VW-1:0] vertex_id;
  logic [CW-1:0] num_edges;
  logic          busy;
  logic          edge_valid;
  logic          edge_ready;
  logic [W-1:0]  edge_page_rank;
  logic [W-1:0]  edge_out_deg;
  logic          red_start;
  logic [W-1:0]  red_sum;
  logic [W-1:0]  red_page_rank;
  logic [W-1:0]  red_out_deg;
  logic [W-1:0]  red_new_sum;
  logic          red_done;
  logic          result_valid;
  logic [VW-1:0] result_vertex;
  logic [W-1:0]  result_sum;
  logic          result_zero_deg;

  always #5 clk = ~clk;

  pagerank_reduce_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .vertex_id(vertex_id), .num_edges(num_edges),
    .busy(busy), .edge_valid(edge_valid), .edge_ready(edge_ready),
    .edge_page_rank(edge_page_rank), .edge_out_deg(edge_out_deg),
    .red_start(red_start), .red_sum(red_sum), .red_page_rank(red_page_rank),
    .red_out_deg(red_out_deg), .red_new_sum(red_new_sum), .red_done(red_done),
    .result_valid(result_valid), .result_vertex(result_vertex), .result_sum(result_sum),
    .result_zero_deg(result_zero_deg)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] q_pr[$];
  logic [W-1:0] q_od[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one job over q_pr/q_od; abort pulls reset while a reduction is outstanding
  task automatic run_job(input logic [VW-1:0] vid, input int stall_at, input int max_d,
                         input bit noise, input bit abort);
    int n, i_edge, handed, done_at, rem, stall_cnt;
    bit pend, hs, exp_rs, seen;
    logic [W-1:0] ref_sum, saved_sum;
    logic ref_z;
    logic [W-1:0] exp_sums[$];
    logic [63:0] prod;

    n = q_pr.size();
    ref_sum = '0;
    ref_z   = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (q_od[i] == 0) ref_z = 1'b1;
      else begin
        exp_sums.push_back(ref_sum);
        ref_sum = ref_sum + q_pr[i] / q_od[i];
      end
    end
`ifdef PAGERANK_DAMPING_EN
    if (n > 0) begin
      prod    = 64'(ref_sum) * 64'd217;
      ref_sum = 32'(prod >> 8) + 32'd38;
    end
`endif

    start      = 1'b1;
    vertex_id  = vid;
    num_edges  = CW'(n);
    edge_valid = 1'b0;
    red_done   = 1'b0;
    i_edge = 0; handed = -1; rem = 0; stall_cnt = 0;
    pend = 1'b0; hs = 1'b0; seen = 1'b0; saved_sum = '0;
    done_at = (n == 0) ? 1 : -1;

    for (int t = 1; t <= 40 + 40 * n && !seen; t++) begin
      step();
      start     = noise && ($urandom % 4 == 0);
      vertex_id = VW'($urandom);
      num_edges = CW'($urandom);

      if (hs) begin
        handed = i_edge;
        i_edge++;
        if (q_od[handed] == 0 && handed == n - 1) done_at = t + DL;
      end
      exp_rs = hs && (q_od[handed] != 0);
      check_eq("red_start", red_start, exp_rs);

      red_done    = 1'b0;
      red_new_sum = $urandom;
      if (red_start) begin
        check_eq("issue_expected", exp_sums.size() > 0, 1);
        if (exp_sums.size() > 0) check_eq("red_sum_issue", red_sum, exp_sums.pop_front());
        if (handed >= 0) begin
          check_eq("red_page_rank", red_page_rank, q_pr[handed]);
          check_eq("red_out_deg", red_out_deg, q_od[handed]);
        end
        pend      = 1'b1;
        rem       = $urandom_range(1, max_d);
        saved_sum = red_sum;
      end else if (pend) begin
        check_eq("red_sum_hold", red_sum, saved_sum);
        check_eq("ready_in_wait", edge_ready, 0);
        if (abort) begin
          reset = 1'b0; start = 1'b0; edge_valid = 1'b0;
          step();
          check_eq("rst_busy", busy, 0);
          check_eq("rst_edge_ready", edge_ready, 0);
          check_eq("rst_red_start", red_start, 0);
          check_eq("rst_result_valid", result_valid, 0);
          check_eq("rst_red_sum", red_sum, 0);
          check_eq("rst_red_page_rank", red_page_rank, 0);
          check_eq("rst_red_out_deg", red_out_deg, 0);
          check_eq("rst_result_sum", result_sum, 0);
          check_eq("rst_result_vertex", result_vertex, 0);
          check_eq("rst_result_zero_deg", result_zero_deg, 0);
          reset = 1'b1; red_done = 1'b1; red_new_sum = 32'hDEAD_BEEF;
          step();
          red_done = 1'b0;
          check_eq("late_done_busy", busy, 0);
          check_eq("late_done_red_sum", red_sum, 0);
          step();
          check_eq("late_done_result_valid", result_valid, 0);
          check_eq("late_done_busy2", busy, 0);
          q_pr.delete();
          q_od.delete();
          return;
        end
        rem--;
        if (rem == 0) begin
          red_done    = 1'b1;
          red_new_sum = red_sum + red_page_rank / red_out_deg;
          pend        = 1'b0;
          if (handed == n - 1) done_at = t + 1 + DL;
        end
      end else if (noise && $urandom % 3 == 0) begin
        red_done = 1'b1;
      end

      check_eq("busy_in_job", busy, 1);
      if (result_valid) begin
        check_eq("result_latency", t, done_at);
        check_eq("result_sum", result_sum, ref_sum);
        check_eq("result_vertex", result_vertex, vid);
        check_eq("result_zero_deg", result_zero_deg, ref_z);
        seen  = 1'b1;
        start = 1'b0;
      end

      if (i_edge < n) begin
        if (!(edge_valid && !hs)) begin
          if (i_edge == stall_at && stall_cnt < 5) begin
            if (stall_cnt > 0) check_eq("ready_during_stall", edge_ready, 1);
            if (edge_ready) stall_cnt++;
            edge_valid = 1'b0;
          end else begin
            edge_valid = noise ? ($urandom % 3 != 0) : 1'b1;
          end
          if (edge_valid) begin
            edge_page_rank = q_pr[i_edge];
            edge_out_deg   = q_od[i_edge];
          end else begin
            edge_page_rank = $urandom;
            edge_out_deg   = $urandom;
          end
        end
      end else begin
        edge_valid = 1'b0;
      end
      hs = edge_valid && edge_ready;
    end

    check_eq("result_seen", seen, 1);
    edge_valid = 1'b0;
    red_done   = 1'b0;
    start      = 1'b0;
    step();
    check_eq("result_pulse_end", result_valid, 0);
    check_eq("busy_after", busy, 0);
    check_eq("all_issued", exp_sums.size(), 0);
    q_pr.delete();
    q_od.delete();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b0; start = 1'b0; vertex_id = '0; num_edges = '0;
    edge_valid = 1'b0; edge_page_rank = '0; edge_out_deg = '0;
    red_new_sum = '0; red_done = 1'b0;
    repeat (3) step();
    check_eq("reset_busy", busy, 0);
    check_eq("reset_edge_ready", edge_ready, 0);
    check_eq("reset_red_start", red_start, 0);
    check_eq("reset_result_valid", result_valid, 0);
    check_eq("reset_red_sum", red_sum, 0);
    check_eq("reset_result_sum", result_sum, 0);
    reset = 1'b1;
    step();

    q_pr = '{32'd6}; q_od = '{32'd2};
    run_job(16'h0011, -1, 1, 1'b0, 1'b0);

    q_pr = '{32'd6, 32'd31, 32'd1407726}; q_od = '{32'd2, 32'd1, 32'd429};
    run_job(16'h0022, 1, 1, 1'b0, 1'b0);

    q_pr = '{32'd6, 32'd10}; q_od = '{32'd0, 32'd5};
    run_job(16'h0033, -1, 2, 1'b0, 1'b0);

    run_job(16'h0044, -1, 1, 1'b0, 1'b0);

    q_pr = '{32'd6}; q_od = '{32'd2};
    run_job(16'h0055, -1, 3, 1'b0, 1'b1);
    q_pr = '{32'd6}; q_od = '{32'd2};
    run_job(16'h0056, -1, 1, 1'b0, 1'b0);

    q_pr = '{32'd6, 32'd31, 32'd1407726}; q_od = '{32'd2, 32'd1, 32'd429};
    run_job(16'h0066, -1, 3, 1'b1, 1'b0);

    repeat (40) begin
      n = $urandom_range(0, 6);
      for (int i = 0; i < n; i++) begin
        q_pr.push_back($urandom);
        if ($urandom % 5 == 0)      q_od.push_back(32'd0);
        else if ($urandom % 2 == 0) q_od.push_back($urandom_range(1, 1000));
        else                        q_od.push_back($urandom | 32'd1);
      end
      run_job(VW'($urandom), $urandom_range(0, 6), 3, 1'b1, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
